// File: rtl/datapath_pkg.sv
// Shared datapath definitions: control-FSM write-back state codes, default
// data width and the register-bank sequencer states.
package datapath_pkg;

  localparam int XLEN_DEF = 32;
  localparam int WR_COUNT_W = 16;

  localparam logic [3:0] WB_STATE_A_DEF = 4'b0110;
  localparam logic [3:0] WB_STATE_B_DEF = 4'b0111;

  typedef enum logic {
    RB_CLEAR = 1'b0,
    RB_RUN   = 1'b1
  } rb_state_e;

endpackage

// File: rtl/regbank_param_if.sv
// Register-bank access bundle: read ports, write-back port, debug port and status.
interface regbank_param_if #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int STATE_W = 4
);

  logic [STATE_W-1:0] state;
  logic [AW-1:0]      rs1;
  logic [AW-1:0]      rs2;
  logic [AW-1:0]      rd;
  logic               regwrite;
  logic               memtoreg;
  logic [XLEN-1:0]    wdata_alu;
  logic [XLEN-1:0]    wdata_mem;
  logic [XLEN-1:0]    rdata1;
  logic [XLEN-1:0]    rdata2;
  logic [AW-1:0]      dbg_addr;
  logic [XLEN-1:0]    dbg_data;
  logic               ready;
  logic [15:0]        wr_count;

  modport master (
    output state, rs1, rs2, rd, regwrite, memtoreg, wdata_alu, wdata_mem, dbg_addr,
    input  rdata1, rdata2, dbg_data, ready, wr_count
  );

  modport slave (
    input  state, rs1, rs2, rd, regwrite, memtoreg, wdata_alu, wdata_mem, dbg_addr,
    output rdata1, rdata2, dbg_data, ready, wr_count
  );

endinterface

// File: rtl/regbank_bypass.sv
// One combinational read port: blanks x0 and the clear sweep, and optionally
// forwards the write committing this cycle.
module regbank_bypass #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] bank_val,
  input  logic            blank,
  input  logic            fwd_en,
  input  logic [AW-1:0]   fwd_addr,
  input  logic [XLEN-1:0] fwd_data,
  output logic [XLEN-1:0] data
);

  logic hit;

  assign hit = BYPASS && fwd_en && (fwd_addr == addr);

  always_comb begin
    data = bank_val;
    if (blank || (addr == '0)) begin
      data = '0;
    end else if (hit) begin
      data = fwd_data;
    end
  end

endmodule

// File: rtl/regbank_param.sv
// Parametrised GPR bank: two combinational read ports, state-gated write-back,
// x0 hardwired to zero, post-reset clear sweep, debug read port and write counter.
module regbank_param
  import datapath_pkg::*;
#(
  parameter int                 XLEN           = XLEN_DEF,
  parameter int                 NREGS          = 32,
  parameter int                 AW             = $clog2(NREGS),
  parameter int                 STATE_W        = 4,
  parameter logic [STATE_W-1:0] WB_STATE_A     = STATE_W'(WB_STATE_A_DEF),
  parameter logic [STATE_W-1:0] WB_STATE_B     = STATE_W'(WB_STATE_B_DEF),
  parameter bit                 BYPASS         = 1'b1,
  parameter bit                 CLEAR_ON_RESET = 1'b1
) (
  input logic            clk,
  input logic            rst,
  regbank_param_if.slave bus
);

  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
    return (v == {WR_COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  rb_state_e              fsm_q, fsm_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   ready_q, ready_d;
  logic [WR_COUNT_W-1:0]  wr_count_q;
  logic [XLEN-1:0]        dbg_data_p1;
  logic [XLEN-1:0]        dbg_next;
  logic [XLEN-1:0]        bank [NREGS];

  logic                   in_clear;
  logic                   in_wb;
  logic                   wr_fire;
  logic [XLEN-1:0]        wdata;

  assign in_clear = (fsm_q == RB_CLEAR);
  assign in_wb    = (bus.state == WB_STATE_A) || (bus.state == WB_STATE_B);
  // ready is only ever high in RUN, so a commit can never collide with a sweep write.
  assign wr_fire  = ready_q && bus.regwrite && (bus.rd != '0) && in_wb;
  assign wdata    = bus.memtoreg ? bus.wdata_mem : bus.wdata_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= CLEAR_ON_RESET ? RB_CLEAR : RB_RUN;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (fsm_q)
      RB_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) begin
          fsm_d   = RB_RUN;
          ready_d = 1'b1;
        end
      end
      RB_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        fsm_d   = RB_RUN;
        ready_d = 1'b0;
      end
    endcase
  end

  // Storage has no reset of its own; a reset edge simply suppresses any write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_clear) begin
        bank[idx_q] <= '0;
      end else if (wr_fire) begin
        bank[bus.rd] <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else if (wr_fire) begin
      wr_count_q <= sat_inc(wr_count_q);
    end
  end

  // Debug stage p1: captures the register value as it stands after this edge's write.
  always_comb begin
    dbg_next = bank[bus.dbg_addr];
    if (in_clear || (bus.dbg_addr == '0)) begin
      dbg_next = '0;
    end else if (wr_fire && (bus.rd == bus.dbg_addr)) begin
      dbg_next = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_data_p1 <= '0;
    end else begin
      dbg_data_p1 <= dbg_next;
    end
  end

  regbank_bypass #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd1 (
    .addr     (bus.rs1),
    .bank_val (bank[bus.rs1]),
    .blank    (in_clear),
    .fwd_en   (wr_fire),
    .fwd_addr (bus.rd),
    .fwd_data (wdata),
    .data     (bus.rdata1)
  );

  regbank_bypass #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd2 (
    .addr     (bus.rs2),
    .bank_val (bank[bus.rs2]),
    .blank    (in_clear),
    .fwd_en   (wr_fire),
    .fwd_addr (bus.rd),
    .fwd_data (wdata),
    .data     (bus.rdata2)
  );

  assign bus.ready    = ready_q;
  assign bus.wr_count = wr_count_q;
  assign bus.dbg_data = dbg_data_p1;

endmodule
